// File: rtl/issue_scheduler.sv
// issue_scheduler: issue-stage hazard checker sitting between the decoder and
// the ALU/mem and multiplier execute paths. In-flight register writers are held
// in a writeback reservation shift register. Slot k holds the writer that
// reaches writeback in k cycles, and slot 0 is writing back in this cycle.
// Issue is held off on RAW, WAW, writeback-port conflicts, downstream stall and
// flush. The block also reports bypass hits from slot 0.
module issue_scheduler #(
  parameter int REG_W     = 5,
  parameter int ALU_LAT   = 2,
  parameter int MUL_LAT   = 5,
  parameter int FLUSH_AGE = 2,
  parameter int R0_ZERO   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_r1,
  input  logic [REG_W-1:0] in_r2,
  input  logic             in_use_r1,
  input  logic             in_use_r2,
  input  logic [REG_W-1:0] in_dst,
  input  logic             in_wr,
  input  logic             in_mul,
  input  logic             ext_stall,
  input  logic             flush,
  output logic             issue,
  output logic             fwd_r1,
  output logic             fwd_r2,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_dst,
  output logic [15:0]      stall_cnt
);

  localparam bit R0_EN = (R0_ZERO != 0);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dst;
    logic [3:0]       age;
  } slot_t;

  slot_t       r_slot     [MUL_LAT];
  slot_t       w_slot_nxt [MUL_LAT];
  logic [15:0] r_stall_cnt;

  logic w_src1, w_src2, w_wr;
  logic w_raw, w_waw, w_port;
  logic w_fwd1, w_fwd2;
  logic w_ready, w_issue;
  int   w_lat;

  // Qualify operands: unused sources and register 0 take part in no compare.
  always_comb begin
    // NOTE: every signal written in always_comb gets a value before any
    // branch. Otherwise a path that leaves it unassigned infers a latch.
    w_src1 = in_use_r1 && !(R0_EN && (in_r1 == '0));
    w_src2 = in_use_r2 && !(R0_EN && (in_r2 == '0));
    w_wr   = in_wr && !(R0_EN && (in_dst == '0));
    w_lat  = in_mul ? MUL_LAT : ALU_LAT;
  end

  // Hazard detection against every occupied reservation slot.
  always_comb begin
    w_raw  = 1'b0;
    w_waw  = 1'b0;
    w_fwd1 = 1'b0;
    w_fwd2 = 1'b0;
    for (int k = 0; k < MUL_LAT; k++) begin
      if (r_slot[k].v) begin
        if (k == 0) begin
          // A writer in slot 0 can be bypassed, so it does not stall issue.
          w_fwd1 = w_fwd1 | (w_src1 && (r_slot[k].dst == in_r1));
          w_fwd2 = w_fwd2 | (w_src2 && (r_slot[k].dst == in_r2));
        end else begin
          w_raw = w_raw | (w_src1 && (r_slot[k].dst == in_r1))
                        | (w_src2 && (r_slot[k].dst == in_r2));
        end
        // An older writer that would land after this one breaks WAW order.
        if (k >= w_lat) begin
          w_waw = w_waw | (w_wr && (r_slot[k].dst == in_dst));
        end
      end
    end
    // Only ALU/load writers can collide on the single writeback port, because
    // the multiplier always enters the empty top slot.
    w_port  = w_wr && !in_mul && r_slot[ALU_LAT].v;
    w_ready = !(w_raw || w_waw || w_port || ext_stall || flush);
    w_issue = in_valid && w_ready;
  end

  // Next reservation state: shift toward writeback, age, flush-kill, insert.
  always_comb begin
    for (int k = 0; k < MUL_LAT; k++) begin
      w_slot_nxt[k] = '0;
    end
    for (int k = 0; k < MUL_LAT - 1; k++) begin
      w_slot_nxt[k].v   = r_slot[k+1].v;
      w_slot_nxt[k].dst = r_slot[k+1].dst;
      w_slot_nxt[k].age = (r_slot[k+1].age == 4'hF) ? 4'hF : r_slot[k+1].age + 4'd1;
      // Flush kills young entries using their age before this shift.
      if (flush && (int'(r_slot[k+1].age) < FLUSH_AGE)) begin
        w_slot_nxt[k] = '0;
      end
    end
    // Port and WAW checks keep the target slot free, so the insert never
    // overwrites a live entry.
    if (w_issue && w_wr) begin
      if (in_mul) begin
        w_slot_nxt[MUL_LAT-1].v   = 1'b1;
        w_slot_nxt[MUL_LAT-1].dst = in_dst;
        w_slot_nxt[MUL_LAT-1].age = 4'd0;
      end else begin
        w_slot_nxt[ALU_LAT-1].v   = 1'b1;
        w_slot_nxt[ALU_LAT-1].dst = in_dst;
        w_slot_nxt[ALU_LAT-1].age = 4'd0;
      end
    end
  end

  // Reservation register. Reset discards every in-flight writer at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is a handful of flops whose valid bits decide hazards,
      // so every entry is reset. A true RAM array would not be.
      for (int k = 0; k < MUL_LAT; k++) begin
        r_slot[k] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // samples pre-edge values, with no race between always blocks.
      r_slot <= w_slot_nxt;
    end
  end

  // Saturating count of cycles where an offered instruction was held off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (in_valid && !w_ready && !flush && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign in_ready  = w_ready;
  assign issue     = w_issue;
  assign fwd_r1    = w_fwd1;
  assign fwd_r2    = w_fwd2;
  assign wb_valid  = r_slot[0].v;
  assign wb_dst    = r_slot[0].dst;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed scenarios plus a randomized run against an
// in-flight writer scoreboard. Each writer is kept as {dst, due cycle, birth cycle}.
module tb_issue_scheduler;

  localparam int REG_W     = 5;
  localparam int ALU_LAT   = 2;
  localparam int MUL_LAT   = 5;
  localparam int FLUSH_AGE = 2;
  localparam int R0_ZERO   = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid, in_ready;
  logic [REG_W-1:0] in_r1, in_r2, in_dst;
  logic             in_use_r1, in_use_r2, in_wr, in_mul;
  logic             ext_stall, flush, issue, fwd_r1, fwd_r2, wb_valid;
  logic [REG_W-1:0] wb_dst;
  logic [15:0]      stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  issue_scheduler #(
    .REG_W(REG_W), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT),
    .FLUSH_AGE(FLUSH_AGE), .R0_ZERO(R0_ZERO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_r1(in_r1), .in_r2(in_r2), .in_use_r1(in_use_r1), .in_use_r2(in_use_r2),
    .in_dst(in_dst), .in_wr(in_wr), .in_mul(in_mul), .ext_stall(ext_stall),
    .flush(flush), .issue(issue), .fwd_r1(fwd_r1), .fwd_r2(fwd_r2),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance one cycle. Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    in_valid = 0; in_r1 = '0; in_r2 = '0; in_use_r1 = 0; in_use_r2 = 0;
    in_dst = '0; in_wr = 0; in_mul = 0; ext_stall = 0; flush = 0;
  endtask

  task automatic set_op(input bit mul, input bit wr, input logic [REG_W-1:0] dst,
                        input bit u1, input logic [REG_W-1:0] r1,
                        input bit u2, input logic [REG_W-1:0] r2);
    in_valid = 1; in_mul = mul; in_wr = wr; in_dst = dst;
    in_use_r1 = u1; in_r1 = r1; in_use_r2 = u2; in_r2 = r2;
    ext_stall = 0; flush = 0;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    in_use_r1 = 1; in_r1 = 5'd3;
    #1;
    n_vec++;
    if ({wb_valid, wb_dst, issue, fwd_r1, fwd_r2, stall_cnt} !== 26'd0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=0", {wb_valid, wb_dst, issue, fwd_r1, fwd_r2, stall_cnt});
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
    ext_stall = 1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready_ext got=%b exp=0", in_ready);
    end
    rst_n = 1;
  endtask

  task automatic test_alu_writeback();
    apply_reset();
    set_op(0, 1, 5'd3, 0, '0, 0, '0);
    #1;
    n_vec++;
    if (issue !== 1'b1) begin n_err++; $display("FAIL alu_issue got=%b exp=1", issue); end
    step(); idle(); #1;
    n_vec++;
    if (wb_valid !== 1'b0) begin n_err++; $display("FAIL alu_wb_early got=%b exp=0", wb_valid); end
    step(); #1;
    n_vec++;
    if ({wb_valid, wb_dst} !== {1'b1, 5'd3}) begin
      n_err++; $display("FAIL alu_wb got=%b/%0d exp=1/3", wb_valid, wb_dst);
    end
    step(); #1;
    n_vec++;
    if (wb_valid !== 1'b0) begin n_err++; $display("FAIL alu_wb_late got=%b exp=0", wb_valid); end
  endtask

  task automatic test_raw_bypass();
    apply_reset();
    set_op(0, 1, 5'd3, 0, '0, 0, '0);
    #1;
    n_vec++;
    if (issue !== 1'b1) begin n_err++; $display("FAIL raw_first_issue got=%b exp=1", issue); end
    step(); set_op(0, 1, 5'd9, 1, 5'd3, 0, '0); #1;
    n_vec++;
    if ({in_ready, issue, fwd_r1} !== 3'b000) begin
      n_err++; $display("FAIL raw_stall got=%b exp=000", {in_ready, issue, fwd_r1});
    end
    step(); #1;
    n_vec++;
    if ({in_ready, issue, fwd_r1, fwd_r2, wb_valid, wb_dst} !== {5'b11101, 5'd3}) begin
      n_err++; $display("FAIL raw_bypass got=%b exp=%b", {in_ready, issue, fwd_r1, fwd_r2, wb_valid, wb_dst}, {5'b11101, 5'd3});
    end
    step(); idle(); #1;
    n_vec++;
    if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL raw_stall_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_port_conflict();
    apply_reset();
    set_op(1, 1, 5'd4, 0, '0, 0, '0);
    #1;
    n_vec++;
    if (issue !== 1'b1) begin n_err++; $display("FAIL port_mul_issue got=%b exp=1", issue); end
    step(); idle(); step(); step();
    set_op(0, 1, 5'd5, 0, '0, 0, '0); #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL port_stall got=%b exp=0", in_ready); end
    step(); #1;
    n_vec++;
    if ({in_ready, issue, wb_valid} !== 3'b110) begin
      n_err++; $display("FAIL port_issue got=%b exp=110", {in_ready, issue, wb_valid});
    end
    step(); idle(); #1;
    n_vec++;
    if ({wb_valid, wb_dst} !== {1'b1, 5'd4}) begin
      n_err++; $display("FAIL port_wb_mul got=%b/%0d exp=1/4", wb_valid, wb_dst);
    end
    step(); #1;
    n_vec++;
    if ({wb_valid, wb_dst} !== {1'b1, 5'd5}) begin
      n_err++; $display("FAIL port_wb_alu got=%b/%0d exp=1/5", wb_valid, wb_dst);
    end
    step(); #1;
    n_vec++;
    if (wb_valid !== 1'b0) begin n_err++; $display("FAIL port_wb_end got=%b exp=0", wb_valid); end
  endtask

  task automatic test_waw();
    apply_reset();
    set_op(1, 1, 5'd6, 0, '0, 0, '0);
    #1;
    n_vec++;
    if (issue !== 1'b1) begin n_err++; $display("FAIL waw_mul_issue got=%b exp=1", issue); end
    for (int c = 1; c <= 3; c++) begin
      step(); set_op(0, 1, 5'd6, 0, '0, 0, '0); #1;
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall_c%0d got=%b exp=0", c, in_ready); end
    end
    step(); #1;
    n_vec++;
    if ({in_ready, issue} !== 2'b11) begin n_err++; $display("FAIL waw_release got=%b exp=11", {in_ready, issue}); end
    for (int c = 5; c <= 6; c++) begin
      step(); idle(); #1;
      n_vec++;
      if ({wb_valid, wb_dst} !== {1'b1, 5'd6}) begin
        n_err++; $display("FAIL waw_wb_c%0d got=%b/%0d exp=1/6", c, wb_valid, wb_dst);
      end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    set_op(1, 1, 5'd8, 0, '0, 0, '0);
    step(); idle(); step();
    set_op(0, 1, 5'd7, 0, '0, 0, '0); #1;
    n_vec++;
    if (issue !== 1'b1) begin n_err++; $display("FAIL flush_alu_issue got=%b exp=1", issue); end
    step(); set_op(1, 1, 5'd10, 0, '0, 0, '0); flush = 1; #1;
    n_vec++;
    if ({in_ready, issue} !== 2'b00) begin n_err++; $display("FAIL flush_block got=%b exp=00", {in_ready, issue}); end
    for (int c = 4; c <= 9; c++) begin
      step(); idle(); #1;
      n_vec++;
      if (c == 5) begin
        if ({wb_valid, wb_dst} !== {1'b1, 5'd8}) begin
          n_err++; $display("FAIL flush_old_wb got=%b/%0d exp=1/8", wb_valid, wb_dst);
        end
      end else if (wb_valid !== 1'b0) begin
        n_err++; $display("FAIL flush_killed_wb_c%0d got=%b/%0d exp=0", c, wb_valid, wb_dst);
      end
    end
    n_vec++;
    if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL flush_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_r0();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      set_op(c[0], 1, 5'd0, 1, 5'd0, 1, 5'd0); #1;
      n_vec++;
      if ({in_ready, issue, fwd_r1, fwd_r2, wb_valid} !== 5'b11000) begin
        n_err++; $display("FAIL r0_c%0d got=%b exp=11000", c, {in_ready, issue, fwd_r1, fwd_r2, wb_valid});
      end
      step();
    end
  endtask

  task automatic test_stall_saturate();
    apply_reset();
    idle(); in_valid = 1; ext_stall = 1; #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL sat_ready got=%b exp=0", in_ready); end
    repeat (100) step();
    #1;
    n_vec++;
    if (stall_cnt !== 16'd100) begin n_err++; $display("FAIL sat_mid got=%0d exp=100", stall_cnt); end
    repeat (69900) step();
    #1;
    n_vec++;
    if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_full got=%h exp=ffff", stall_cnt); end
    idle();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    set_op(1, 1, 5'd11, 0, '0, 0, '0);
    step(); idle(); step();
    #2; rst_n = 0; #1;
    n_vec++;
    if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_now got=%b exp=0", wb_valid); end
    step(); rst_n = 1;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_vec++;
      if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_c%0d got=%b/%0d exp=0", c, wb_valid, wb_dst); end
      step();
    end
  endtask

  typedef struct {
    logic [REG_W-1:0] dst;
    int               due;
    int               born;
  } writer_t;

  task automatic test_random();
    writer_t     q[$];
    int          now = 0;
    logic [15:0] m_cnt = '0;
    apply_reset();
    for (int it = 0; it < 3000; it++) begin
      bit               e_rdy, e_iss, e_f1, e_f2, e_wb, raw, waw, port, s1, s2, wr;
      logic [REG_W-1:0] e_wbdst;
      logic [25:0]      got, exp;
      int               lat, idx;
      in_valid  = ($urandom_range(0, 9) < 7);
      in_mul    = ($urandom_range(0, 9) < 3);
      in_wr     = ($urandom_range(0, 9) < 8);
      in_use_r1 = ($urandom_range(0, 9) < 6);
      in_use_r2 = ($urandom_range(0, 9) < 6);
      in_r1     = 5'($urandom_range(0, 3));
      in_r2     = 5'($urandom_range(0, 3));
      in_dst    = 5'($urandom_range(0, 3));
      ext_stall = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      lat = in_mul ? MUL_LAT : ALU_LAT;
      s1  = in_use_r1 && (in_r1 != 0);
      s2  = in_use_r2 && (in_r2 != 0);
      wr  = in_wr && (in_dst != 0);
      e_wb = 0; e_wbdst = '0; e_f1 = 0; e_f2 = 0; raw = 0; waw = 0; port = 0;
      foreach (q[i]) begin
        idx = q[i].due - now;
        if (idx == 0) begin
          e_wb = 1; e_wbdst = q[i].dst;
          if (s1 && q[i].dst == in_r1) e_f1 = 1;
          if (s2 && q[i].dst == in_r2) e_f2 = 1;
        end else if ((s1 && q[i].dst == in_r1) || (s2 && q[i].dst == in_r2)) begin
          raw = 1;
        end
        if (wr && idx >= lat && q[i].dst == in_dst) waw = 1;
        if (wr && !in_mul && idx == ALU_LAT) port = 1;
      end
      e_rdy = !(raw || waw || port || ext_stall || flush);
      e_iss = in_valid && e_rdy;
      got = {in_ready, issue, fwd_r1, fwd_r2, wb_valid, (wb_valid ? wb_dst : 5'd0), stall_cnt};
      exp = {e_rdy, e_iss, e_f1, e_f2, e_wb, e_wbdst, m_cnt};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random it=%0d got=%b exp=%b (rdy,iss,f1,f2,wbv,wbd,cnt)", it, got, exp);
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due == now) q.delete(i);
        else if (flush && (now - q[i].born) < FLUSH_AGE) q.delete(i);
      end
      if (e_iss && wr) q.push_back('{dst: in_dst, due: now + lat, born: now + 1});
      if (in_valid && !e_rdy && !flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      now++;
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_writeback();
    test_raw_bypass();
    test_port_conflict();
    test_waw();
    test_flush();
    test_r0();
    test_reset_midflight();
    test_random();
    test_stall_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
